aes_key_scheduler: RTL and testbench
====================================

AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 key_in  input  128  cipher key; bits [127:96] are word w0.
REQ-005 key_valid  input  1  key_in is valid this cycle.
REQ-006 key_ready  output  1  scheduler can accept a key; high only in IDLE.
REQ-007 rk_out  output  128  current round key.
REQ-008 rk_idx  output  4  round index of rk_out, 0..10.
REQ-009 rk_valid  output  1  rk_out/rk_idx are valid.
REQ-010 rk_ready  input  1  downstream accepts rk_out.
REQ-011 busy  output  1  high in EMIT state.
REQ-012 done  output  1  one-cycle pulse after round key 10 is accepted.
REQ-013 rd_idx  input  4  store read index (only with AES_RKEY_STORE_EN).
REQ-014 rd_key  output  128  stored round key at rd_idx (only with AES_RKEY_STORE_EN).
REQ-015 store_valid  output  1  store holds a complete schedule (only with AES_RKEY_STORE_EN).

Function
REQ-016 FSM states SHALL be IDLE and EMIT; IDLE->EMIT on key_valid && key_ready; EMIT->IDLE on rk_valid && rk_ready with rk_idx==10.
REQ-017 On key acceptance in cycle N, rk_valid SHALL be high in cycle N+1 with rk_idx=0 and rk_out=key_in as captured.
REQ-018 On each handshake with rk_idx=k<10, the next cycle SHALL present rk_idx=k+1 and rk_out = one-round expansion of the previous rk_out using round constant index k (rcon 01,02,04,08,10,20,40,80,1b,36).
REQ-019 Throughput SHALL be one round key per cycle while rk_ready stays high; 11 keys in 11 cycles.
REQ-020 While rk_valid && !rk_ready, rk_out and rk_idx SHALL remain stable.
REQ-021 key_valid SHALL be ignored in EMIT; key_in is sampled only on acceptance.
REQ-022 done SHALL pulse in the cycle after the rk_idx=10 handshake, coincident with key_ready returning high.
REQ-023 A new key presented in that same cycle SHALL be accepted (back-to-back schedules, no gap cycle beyond done).
REQ-024 rk_idx SHALL never exceed 10; rk_valid SHALL be low in IDLE.

Reset
REQ-025 rst SHALL force IDLE, key_ready=1, rk_valid=0, rk_idx=0, rk_out=0, busy=0, done=0 on the next edge.
REQ-026 rst asserted mid-EMIT SHALL abandon the schedule with no further rk_valid or done.
REQ-027 With the macro, rst SHALL clear store_valid; store contents need not be cleared.

Configuration
REQ-028 Macro AES_RKEY_STORE_EN defined: an 11x128 register store SHALL write each round key at its index when it is loaded into rk_out; store_valid SHALL set with done and clear on the next key acceptance; rd_key = entry[rd_idx] combinationally, 0 for rd_idx>10.
REQ-029 Macro undefined: rd_idx, rd_key and store_valid ports and the store SHALL be absent; streaming behaviour unchanged.

Structure
REQ-030 Package aes_pkg SHALL hold AES_NR=10, AES_NUM_RKEYS=11, the 128-bit key typedef and the FSM state enum.
REQ-031 The existing single-round key_expansion module SHALL be instantiated once as the sole sub-module, fed by the rk_out register and the round counter.

Verification
REQ-032 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx1 a0fafe1788542cb123a339392a6c7605, idx10 d014f9a8c9ee2589e13f0cc8b6630ca6, done one cycle later.
REQ-033 All-zero key -> idx0 all zeros, idx1 62636363626363636263636362636363.
REQ-034 rk_ready held low 5 cycles at idx 3 -> rk_out/rk_idx stable, idx4 correct after release.
REQ-035 rst pulsed at idx 6 -> IDLE next cycle, no done, fresh key then yields correct full schedule.
REQ-036 Two keys back-to-back, key_valid held high -> second accepted in done cycle, both schedules correct.
REQ-037 With AES_RKEY_STORE_EN, after REQ-032 schedule -> rd_idx=10 returns d014f9a8..., rd_idx=12 returns 0, store_valid clears on next acceptance.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round counts, key type, FSM states and round constants.
package aes_pkg;

    localparam int AES_NR        = 10;
    localparam int AES_NUM_RKEYS = 11;

    typedef logic [127:0] aes_key_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ks_state_t;

    function automatic logic [7:0] aes_rcon(input logic [3:0] k);
        logic [7:0] r;
        case (k)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_expansion.sv
// Single AES-128 key-expansion round: RotWord, SubWord and rcon mixing, then the w0..w3 XOR chain.
module key_expansion
    import aes_pkg::*;
(
    input  aes_key_t    prev_key,
    input  logic [3:0]  rcon_idx,
    output aes_key_t    next_key
);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    logic [31:0] w0, w1, w2, w3, rot, temp;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        {w0, w1, w2, w3} = prev_key;
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]) ^ aes_rcon(rcon_idx), sbox(rot[23:16]),
                sbox(rot[15:8]), sbox(rot[7:0])};
        n0 = w0 ^ temp;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_scheduler.sv
// Streams the 11 AES-128 round keys for an accepted cipher key, one per handshake.
// Optional AES_RKEY_STORE_EN adds an 11-entry readable round-key store.
module aes_key_scheduler
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  aes_key_t    key_in,
    input  logic        key_valid,
    output logic        key_ready,
    output aes_key_t    rk_out,
    output logic [3:0]  rk_idx,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic        busy,
    output logic        done
`ifdef AES_RKEY_STORE_EN
    ,
    input  logic [3:0]  rd_idx,
    output aes_key_t    rd_key,
    output logic        store_valid
`endif
);

    ks_state_t state, next_state;
    aes_key_t  next_rk;
    logic      accept, advance, finish;

    key_expansion u_key_expansion (
        .prev_key (rk_out),
        .rcon_idx (rk_idx),
        .next_key (next_rk)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        key_ready  = 1'b0;
        rk_valid   = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    accept     = 1'b1;
                    next_state = ST_EMIT;
                end
            end
            ST_EMIT: begin
                rk_valid = 1'b1;
                busy     = 1'b1;
                if (rk_ready) begin
                    if (rk_idx == 4'(AES_NR)) begin
                        finish     = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_out <= '0;
            rk_idx <= '0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                rk_out <= key_in;
                rk_idx <= '0;
            end else if (advance) begin
                rk_out <= next_rk;
                rk_idx <= rk_idx + 4'd1;
            end
        end
    end

`ifdef AES_RKEY_STORE_EN
    aes_key_t store [AES_NUM_RKEYS];

    // Contents are deliberately not reset; store_valid qualifies them.
    always_ff @(posedge clk) begin
        if (accept)
            store[0] <= key_in;
        else if (advance)
            store[rk_idx + 4'd1] <= next_rk;
    end

    always_ff @(posedge clk) begin
        if (rst)         store_valid <= 1'b0;
        else if (accept) store_valid <= 1'b0;
        else if (finish) store_valid <= 1'b1;
    end

    assign rd_key = (rd_idx < 4'(AES_NUM_RKEYS)) ? store[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Directed, table-driven bench for aes_key_scheduler (store checks when AES_RKEY_STORE_EN is defined).
module tb_aes_key_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;
`ifdef AES_RKEY_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         store_valid;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
    } rk_vec_t;

    rk_vec_t fips_tbl [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    aes_key_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy),
        .done      (done)
`ifdef AES_RKEY_STORE_EN
        ,
        .rd_idx      (rd_idx),
        .rd_key      (rd_key),
        .store_valid (store_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects the DUT to be presenting idx 0 of the FIPS key; checks every key and the done cycle.
    task automatic check_fips_stream(input string tag);
        for (int i = 0; i < 11; i++) begin
            check({tag, " rk_valid"}, 128'(rk_valid), 128'(1));
            check({tag, " rk_idx"}, 128'(rk_idx), 128'(fips_tbl[i].idx));
            check({tag, " rk_out"}, rk_out, fips_tbl[i].rk);
            step();
        end
        check({tag, " done"}, 128'(done), 128'(1));
        check({tag, " key_ready at done"}, 128'(key_ready), 128'(1));
        check({tag, " rk_valid at done"}, 128'(rk_valid), 128'(0));
    endtask

    initial begin
        fips_tbl[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        fips_tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        fips_tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        fips_tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        fips_tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        fips_tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        fips_tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        fips_tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        fips_tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        fips_tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        fips_tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_ready  = 1'b0;
`ifdef AES_RKEY_STORE_EN
        rd_idx    = '0;
`endif
        step();
        step();
        check("reset key_ready", 128'(key_ready), 128'(1));
        check("reset rk_valid", 128'(rk_valid), 128'(0));
        check("reset rk_idx", 128'(rk_idx), 128'(0));
        check("reset rk_out", rk_out, 128'h0);
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
`ifdef AES_RKEY_STORE_EN
        check("reset store_valid", 128'(store_valid), 128'(0));
`endif
        rst = 1'b0;
        step();

        // FIPS-197 key with continuous rk_ready
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        step();
        key_valid = 1'b0;
        key_in    = '1;
        check("busy in emit", 128'(busy), 128'(1));
        check("key_ready in emit", 128'(key_ready), 128'(0));
        check_fips_stream("fips");
        step();
        check("done one-cycle", 128'(done), 128'(0));
`ifdef AES_RKEY_STORE_EN
        check("store_valid after sched", 128'(store_valid), 128'(1));
        rd_idx = 4'd10;
        #1;
        check("store rd 10", rd_key, fips_tbl[10].rk);
        rd_idx = 4'd4;
        #1;
        check("store rd 4", rd_key, fips_tbl[4].rk);
        rd_idx = 4'd12;
        #1;
        check("store rd 12", rd_key, 128'h0);
`endif

        // All-zero key; key_valid pulsed while EMIT must be ignored
        key_in    = ZERO_KEY;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
`ifdef AES_RKEY_STORE_EN
        check("store_valid cleared on accept", 128'(store_valid), 128'(0));
`endif
        check("zero idx0", rk_out, 128'h0);
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        check("zero idx1 rk_idx", 128'(rk_idx), 128'(1));
        check("zero idx1", rk_out, 128'h62636363626363636263636362636363);
        begin
            int budget = 20;
            while (!done && budget > 0) begin
                step();
                budget--;
            end
            check("zero sched done reached", 128'(done), 128'(1));
        end
        step();

        // Stall for 5 cycles at idx 3
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("stall pre idx", 128'(rk_idx), 128'(3));
        rk_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall rk_idx", 128'(rk_idx), 128'(3));
            check("stall rk_out", rk_out, fips_tbl[3].rk);
            check("stall rk_valid", 128'(rk_valid), 128'(1));
        end
        rk_ready = 1'b1;
        step();
        check("stall release idx", 128'(rk_idx), 128'(4));
        check("stall release rk", rk_out, fips_tbl[4].rk);
        for (int i = 0; i < 7; i++) step();
        check("stall sched done", 128'(done), 128'(1));
        step();

        // Reset mid-schedule at idx 6
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("pre-rst idx", 128'(rk_idx), 128'(6));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid-rst key_ready", 128'(key_ready), 128'(1));
        check("mid-rst rk_valid", 128'(rk_valid), 128'(0));
        check("mid-rst rk_idx", 128'(rk_idx), 128'(0));
        check("mid-rst rk_out", rk_out, 128'h0);
        check("mid-rst busy", 128'(busy), 128'(0));
        for (int i = 0; i < 6; i++) begin
            step();
            check("post-rst no done", 128'(done), 128'(0));
            check("post-rst no rk_valid", 128'(rk_valid), 128'(0));
        end
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        check_fips_stream("post-rst");
        step();

        // Back-to-back: zero key then FIPS key, key_valid held high throughout
        key_in    = ZERO_KEY;
        key_valid = 1'b1;
        step();
        key_in = FIPS_KEY;
        check("b2b first idx0", rk_out, 128'h0);
        step();
        check("b2b first idx1", rk_out, 128'h62636363626363636263636362636363);
        for (int i = 0; i < 9; i++) step();
        check("b2b first idx10 idx", 128'(rk_idx), 128'(10));
        step();
        check("b2b done", 128'(done), 128'(1));
        check("b2b key_ready in done", 128'(key_ready), 128'(1));
        step();
        key_valid = 1'b0;
        check_fips_stream("b2b second");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
